// File: rtl/apb_master_arbiter.sv
// rtl/apb_master_arbiter.sv - round-robin APB master sharing one APB bus between NUM_REQ requesters
// Optional feature macro: APB_TIMEOUT_EN (bounds ACCESS-phase wait states to TIMEOUT cycles)
module apb_master_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                                           PCLK,
  input  logic                                           PRESETn,
  input  logic [NUM_REQ-1:0]                             req_valid,
  output logic [NUM_REQ-1:0]                             req_ready,
  input  logic [NUM_REQ-1:0]                             req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]                      req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]                      req_wdata,
  output logic                                           rsp_valid,
  output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] rsp_id,
  output logic [DATA_W-1:0]                              rsp_rdata,
  output logic                                           rsp_err,
  output logic [ADDR_W-1:0]                              PADDR,
  output logic                                           PSELx,
  output logic                                           PENABLE,
  output logic                                           PWRITE,
  output logic [DATA_W-1:0]                              PWDATA,
  input  logic                                           PREADY,
  input  logic [DATA_W-1:0]                              PRDATA,
  input  logic                                           PSLVERR
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                  state, state_nxt;
  logic [ID_W-1:0]         grant, grant_nxt;
  logic [ID_W-1:0]         last_grant, last_grant_nxt;
  logic [ID_W-1:0]         pick;
  logic                    pick_found;
  int                      cand;
  logic [NUM_REQ*ADDR_W-1:0] addr_sh;
  logic [NUM_REQ*DATA_W-1:0] wdata_sh;

  logic [NUM_REQ-1:0]      req_ready_nxt;
  logic                    rsp_valid_nxt, rsp_err_nxt;
  logic [ID_W-1:0]         rsp_id_nxt;
  logic [DATA_W-1:0]       rsp_rdata_nxt, pwdata_nxt;
  logic [ADDR_W-1:0]       paddr_nxt;
  logic                    psel_nxt, penable_nxt, pwrite_nxt;
  logic                    done, done_err;
  logic [DATA_W-1:0]       done_rdata;
`ifdef APB_TIMEOUT_EN
  logic [7:0]              wait_cnt, wait_cnt_nxt;
`endif

  // Round-robin pick: first active requester searching upward from last_grant+1, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick       = '0;
    cand       = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(last_grant) + k) % NUM_REQ;
      if (!pick_found && req_valid[cand[ID_W-1:0]]) begin
        pick_found = 1'b1;
        pick       = cand[ID_W-1:0];
      end
    end
  end

  // Steer the picked requester's address and write data down to bit 0.
  always_comb begin
    addr_sh  = req_addr >> (int'(pick) * ADDR_W);
    wdata_sh = req_wdata >> (int'(pick) * DATA_W);
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    req_ready_nxt  = '0;
    rsp_valid_nxt  = 1'b0;
    rsp_id_nxt     = rsp_id;
    rsp_rdata_nxt  = rsp_rdata;
    rsp_err_nxt    = rsp_err;
    paddr_nxt      = PADDR;
    pwdata_nxt     = PWDATA;
    pwrite_nxt     = PWRITE;
    psel_nxt       = PSELx;
    penable_nxt    = PENABLE;
    done           = 1'b0;
    done_err       = 1'b0;
    done_rdata     = '0;
`ifdef APB_TIMEOUT_EN
    wait_cnt_nxt   = wait_cnt;
`endif
    case (state)
      IDLE: begin
        if (pick_found) begin
          grant_nxt            = pick;
          req_ready_nxt[pick]  = 1'b1;
          paddr_nxt            = addr_sh[ADDR_W-1:0];
          pwdata_nxt           = wdata_sh[DATA_W-1:0];
          pwrite_nxt           = req_write[pick];
          psel_nxt             = 1'b1;
          penable_nxt          = 1'b0;
          state_nxt            = SETUP;
        end
      end
      SETUP: begin
        penable_nxt = 1'b1;
        state_nxt   = ACCESS;
`ifdef APB_TIMEOUT_EN
        wait_cnt_nxt = '0;
`endif
      end
      ACCESS: begin
        if (PREADY) begin
          done       = 1'b1;
          done_err   = PSLVERR;
          done_rdata = PWRITE ? '0 : PRDATA;
        end
`ifdef APB_TIMEOUT_EN
        else if (wait_cnt == 8'(TIMEOUT - 1)) begin
          done     = 1'b1;
          done_err = 1'b1;
        end else begin
          wait_cnt_nxt = wait_cnt + 8'd1;
        end
`endif
        if (done) begin
          psel_nxt       = 1'b0;
          penable_nxt    = 1'b0;
          rsp_valid_nxt  = 1'b1;
          rsp_id_nxt     = grant;
          rsp_rdata_nxt  = done_rdata;
          rsp_err_nxt    = done_err;
          last_grant_nxt = grant;
          state_nxt      = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and output registers; reset aborts any transfer and favours requester 0.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= ID_W'(NUM_REQ - 1);
      req_ready  <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      PADDR      <= '0;
      PWDATA     <= '0;
      PWRITE     <= 1'b0;
      PSELx      <= 1'b0;
      PENABLE    <= 1'b0;
`ifdef APB_TIMEOUT_EN
      wait_cnt   <= '0;
`endif
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
      req_ready  <= req_ready_nxt;
      rsp_valid  <= rsp_valid_nxt;
      rsp_id     <= rsp_id_nxt;
      rsp_rdata  <= rsp_rdata_nxt;
      rsp_err    <= rsp_err_nxt;
      PADDR      <= paddr_nxt;
      PWDATA     <= pwdata_nxt;
      PWRITE     <= pwrite_nxt;
      PSELx      <= psel_nxt;
      PENABLE    <= penable_nxt;
`ifdef APB_TIMEOUT_EN
      wait_cnt   <= wait_cnt_nxt;
`endif
    end
  end
endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb/tb_apb_master_arbiter.sv - self-checking bench for apb_master_arbiter
module tb_apb_master_arbiter;
  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_write = '0;
  logic [1:0]  req_ready;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        rsp_valid;
  logic [0:0]  rsp_id;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] PADDR, PWDATA;
  logic        PSELx, PENABLE, PWRITE;
  logic        PREADY = 1'b1;
  logic [31:0] PRDATA = '0;
  logic        PSLVERR = 1'b0;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int psel_cnt = 0;
  int rsp_cnt = 0;

  always #5 PCLK = ~PCLK;

  apb_master_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PADDR(PADDR), .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
  );

  // ---------------- behavioural model ----------------
  function automatic int rr_pick(logic [1:0] v, int last);
    logic [1:0] s;
    for (int k = 1; k <= NUM_REQ; k++) begin
      s = v >> ((last + k) % NUM_REQ);
      if (s[0]) return (last + k) % NUM_REQ;
    end
    return -1;
  endfunction

  function automatic logic [31:0] slot(logic [63:0] v, int i);
    logic [63:0] s;
    s = v >> (i * 32);
    return s[31:0];
  endfunction

  function automatic logic bitof(logic [1:0] v, int i);
    logic [1:0] s;
    s = v >> i;
    return s[0];
  endfunction

  function automatic logic timed_out(int waited);
`ifdef APB_TIMEOUT_EN
    return (waited + 1 == TIMEOUT);
`else
    return (waited < 0);
`endif
  endfunction

  logic [1:0]  e_ready;
  logic        e_rsp_valid, e_rsp_err, e_psel, e_pen, e_pwrite;
  logic [0:0]  e_rsp_id;
  logic [31:0] e_rdata, e_paddr, e_pwdata;
  int          m_last, m_id, m_phase, m_waited;
  int          m_pick;
  assign m_pick = rr_pick(req_valid, m_last);

  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      e_ready <= '0; e_rsp_valid <= 1'b0; e_rsp_err <= 1'b0; e_rsp_id <= '0; e_rdata <= '0;
      e_psel <= 1'b0; e_pen <= 1'b0; e_pwrite <= 1'b0; e_paddr <= '0; e_pwdata <= '0;
      m_last <= NUM_REQ - 1; m_id <= 0; m_phase <= 0; m_waited <= 0;
    end else begin
      e_ready     <= '0;
      e_rsp_valid <= 1'b0;
      if (m_phase == 0) begin
        if (m_pick >= 0) begin
          e_ready  <= 2'b01 << m_pick;
          e_paddr  <= slot(req_addr, m_pick);
          e_pwdata <= slot(req_wdata, m_pick);
          e_pwrite <= bitof(req_write, m_pick);
          e_psel   <= 1'b1;
          e_pen    <= 1'b0;
          m_id     <= m_pick;
          m_phase  <= 1;
        end
      end else if (m_phase == 1) begin
        e_pen    <= 1'b1;
        m_waited <= 0;
        m_phase  <= 2;
      end else begin
        if (PREADY || timed_out(m_waited)) begin
          e_psel      <= 1'b0;
          e_pen       <= 1'b0;
          e_rsp_valid <= 1'b1;
          e_rsp_id    <= 1'(m_id);
          e_rsp_err   <= PREADY ? PSLVERR : 1'b1;
          e_rdata     <= (PREADY && !e_pwrite) ? PRDATA : 32'h0;
          m_last      <= m_id;
          m_phase     <= 0;
        end else begin
          m_waited <= m_waited + 1;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  function automatic int diff(string nm, logic [31:0] a, logic [31:0] e);
    if (a !== e) begin
      $display("FAIL cyc%0d %s: got %h expected %h", cyc, nm, a, e);
      return 1;
    end
    return 0;
  endfunction

  always @(negedge PCLK) begin
    int bad;
    bad = 0;
    bad += diff("req_ready", 32'(req_ready), 32'(e_ready));
    bad += diff("rsp_valid", 32'(rsp_valid), 32'(e_rsp_valid));
    bad += diff("rsp_id", 32'(rsp_id), 32'(e_rsp_id));
    bad += diff("rsp_rdata", rsp_rdata, e_rdata);
    bad += diff("rsp_err", 32'(rsp_err), 32'(e_rsp_err));
    bad += diff("PADDR", PADDR, e_paddr);
    bad += diff("PWDATA", PWDATA, e_pwdata);
    bad += diff("PWRITE", 32'(PWRITE), 32'(e_pwrite));
    bad += diff("PSELx", 32'(PSELx), 32'(e_psel));
    bad += diff("PENABLE", 32'(PENABLE), 32'(e_pen));
    bad += diff("penable_without_psel", 32'(!PSELx && PENABLE), 32'h0);
    tests++;
    if (bad != 0) fails++;
  end

  always @(posedge PCLK) cyc <= cyc + 1;
  always @(negedge PCLK) begin
    if (PSELx) psel_cnt <= psel_cnt + 1;
    if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
  end

  // ---------------- directed stimulus ----------------
  task automatic check(string nm, logic [31:0] a, logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  task automatic step(int n);
    repeat (n) begin
      @(posedge PCLK);
      #1;
    end
  endtask

  task automatic do_req(int id, logic wr, logic [31:0] a, logic [31:0] d, output int acc);
    req_write[id] = wr;
    req_addr[id*32 +: 32] = a;
    req_wdata[id*32 +: 32] = d;
    req_valid[id] = 1'b1;
    acc = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge PCLK);
      if (req_ready[id]) begin
        acc = cyc;
        break;
      end
    end
    if (acc < 0) begin
      tests++; fails++;
      $display("FAIL accept_timeout id%0d: got no req_ready expected a pulse", id);
    end
    @(posedge PCLK);
    #1;
    req_valid[id] = 1'b0;
  endtask

  task automatic wait_rsp(output int rc, output logic [31:0] rd, output logic er, output logic [0:0] rid);
    rc = -1; rd = '0; er = 1'b0; rid = '0;
    for (int i = 0; i < 60; i++) begin
      @(negedge PCLK);
      if (rsp_valid) begin
        rc = cyc; rd = rsp_rdata; er = rsp_err; rid = rsp_id;
        break;
      end
    end
    if (rc < 0) begin
      tests++; fails++;
      $display("FAIL rsp_timeout: got no rsp_valid expected a pulse");
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100us");
    $fatal(1);
  end

  initial begin
    int acc, rc, p0, r0;
    logic [31:0] rd;
    logic er;
    logic [0:0] rid;
    int gq[$];

    // reset state
    step(2);
    check("reset_psel", 32'(PSELx), 32'h0);
    check("reset_paddr", PADDR, 32'h0);
    check("reset_ready", 32'(req_ready), 32'h0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    PRESETn = 1'b1;
    step(2);

    // single write, no wait states
    p0 = psel_cnt;
    do_req(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, acc);
    wait_rsp(rc, rd, er, rid);
    step(1);
    check("t1_latency", 32'(rc - acc), 32'd2);
    check("t1_rsp_id", 32'(rid), 32'd0);
    check("t1_rsp_err", 32'(er), 32'd0);
    check("t1_rsp_rdata", rd, 32'h0);
    check("t1_psel_cycles", 32'(psel_cnt - p0), 32'd2);
    check("t1_paddr_hold", PADDR, 32'h0000_0010);
    check("t1_pwdata_hold", PWDATA, 32'hDEAD_BEEF);

    // read with 3 wait states
    PREADY = 1'b0;
    PRDATA = 32'h1234_5678;
    p0 = psel_cnt;
    do_req(1, 1'b0, 32'h0000_0024, 32'h0, acc);
    step(3);
    PREADY = 1'b1;
    wait_rsp(rc, rd, er, rid);
    step(1);
    check("t2_latency", 32'(rc - acc), 32'd5);
    check("t2_rsp_id", 32'(rid), 32'd1);
    check("t2_rsp_rdata", rd, 32'h1234_5678);
    check("t2_psel_cycles", 32'(psel_cnt - p0), 32'd5);

    // fairness with both requesters held
    req_write = 2'b11;
    req_addr = {32'h0000_0200, 32'h0000_0100};
    req_wdata = {32'hBBBB_0001, 32'hAAAA_0000};
    r0 = rsp_cnt;
    req_valid = 2'b11;
    for (int i = 0; i < 40 && gq.size() < 4; i++) begin
      @(negedge PCLK);
      if (req_ready != 2'b00) begin
        check("t3_ready_onehot", 32'($countones(req_ready)), 32'd1);
        gq.push_back(req_ready[1] ? 1 : 0);
      end
    end
    @(posedge PCLK);
    #1;
    req_valid = 2'b00;
    step(4);
    check("t3_grant_count", 32'(gq.size()), 32'd4);
    while (gq.size() < 4) gq.push_back(-1);
    check("t3_grant0", 32'(gq[0]), 32'd0);
    check("t3_grant1", 32'(gq[1]), 32'd1);
    check("t3_grant2", 32'(gq[2]), 32'd0);
    check("t3_grant3", 32'(gq[3]), 32'd1);
    check("t3_rsp_count", 32'(rsp_cnt - r0), 32'd4);

    // slave error then a clean transfer
    PSLVERR = 1'b1;
    PRDATA = 32'hA5A5_0001;
    do_req(0, 1'b0, 32'h0000_0040, 32'h0, acc);
    wait_rsp(rc, rd, er, rid);
    check("t4_err_set", 32'(er), 32'd1);
    check("t4_err_rdata", rd, 32'hA5A5_0001);
    step(1);
    PSLVERR = 1'b0;
    do_req(1, 1'b1, 32'h0000_0044, 32'h0000_0055, acc);
    wait_rsp(rc, rd, er, rid);
    check("t4_err_clear", 32'(er), 32'd0);
    check("t4_write_rdata", rd, 32'h0);
    check("t4_rsp_id", 32'(rid), 32'd1);
    step(1);

    // reset during ACCESS wait states
    PREADY = 1'b0;
    do_req(0, 1'b0, 32'h0000_0080, 32'h0, acc);
    step(2);
    PRESETn = 1'b0;
    #1;
    check("t5_psel", 32'(PSELx), 32'h0);
    check("t5_penable", 32'(PENABLE), 32'h0);
    check("t5_paddr", PADDR, 32'h0);
    check("t5_rsp_rdata", rsp_rdata, 32'h0);
    step(2);
    PRESETn = 1'b1;
    PREADY = 1'b1;
    r0 = rsp_cnt;
    p0 = psel_cnt;
    step(10);
    check("t5_no_rsp", 32'(rsp_cnt - r0), 32'd0);
    check("t5_no_reissue", 32'(psel_cnt - p0), 32'd0);

    // long wait: timeout when enabled, indefinite hold otherwise
    PRDATA = 32'hFFFF_0000;
    PREADY = 1'b0;
`ifdef APB_TIMEOUT_EN
    p0 = psel_cnt;
    do_req(0, 1'b0, 32'h0000_0090, 32'h0, acc);
    wait_rsp(rc, rd, er, rid);
    step(1);
    check("t6_latency", 32'(rc - acc), 32'd17);
    check("t6_err", 32'(er), 32'd1);
    check("t6_rdata", rd, 32'h0);
    check("t6_psel_cycles", 32'(psel_cnt - p0), 32'd17);
    PREADY = 1'b1;
`else
    r0 = rsp_cnt;
    do_req(0, 1'b0, 32'h0000_0090, 32'h0, acc);
    step(30);
    check("t6_no_rsp", 32'(rsp_cnt - r0), 32'd0);
    check("t6_psel_held", 32'(PSELx), 32'd1);
    check("t6_penable_held", 32'(PENABLE), 32'd1);
    PREADY = 1'b1;
    wait_rsp(rc, rd, er, rid);
    check("t6_err", 32'(er), 32'd0);
    check("t6_rdata", rd, 32'hFFFF_0000);
`endif
    step(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
